// File: rtl/operand_recover_if.sv
// operand_recover_if: handshake and status bundle for operand_recover.
//   Upstream side  : in_valid/in_ready, result_a (WIDTH), result_b (NARROW)
//   Downstream side: out_valid/out_ready, a_rec (WIDTH), mismatch
//   Error status   : err_cnt (CNT_W), err_sticky, clr (synchronous clear)
// The master modport is the environment and the slave modport is the recover stage.
interface operand_recover_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NARROW = 7,
  parameter int unsigned CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  result_a;
  logic [NARROW-1:0] result_b;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  a_rec;
  logic              mismatch;
  logic [CNT_W-1:0]  err_cnt;
  logic              err_sticky;
  logic              clr;

  modport master (
    output in_valid, result_a, result_b, out_ready, clr,
    input  in_ready, out_valid, a_rec, mismatch, err_cnt, err_sticky
  );

  modport slave (
    input  in_valid, result_a, result_b, out_ready, clr,
    output in_ready, out_valid, a_rec, mismatch, err_cnt, err_sticky
  );
endinterface

// File: rtl/operand_recover.sv
// operand_recover: two-stage registered inverse of the wide/narrow incrementer pair.
// Recovers a_rec = result_a - 1 and b_rec = result_b - 1, and flags beats whose low
// NARROW bits disagree. It also keeps a saturating count and a sticky flag of the
// mismatching beats that are delivered.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : operand_recover_if.slave (in/out handshakes, data, error status, clr)
module operand_recover #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NARROW = 7,
  parameter int unsigned CNT_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  operand_recover_if.slave  bus
);

  // Stage 1: raw incremented values
  logic              r_s1_valid;
  logic [WIDTH-1:0]  r_s1_a;
  logic [NARROW-1:0] r_s1_b;

  // Stage 2: recovered operand and cross-check result
  logic              r_s2_valid;
  logic [WIDTH-1:0]  r_s2_a;
  logic              r_s2_mismatch;

  // Error accounting
  logic [CNT_W-1:0]  r_err_cnt;
  logic              r_err_sticky;

  logic              w_s2_ready;
  logic              w_s1_ready;
  logic              w_in_xfer;
  logic              w_s1_to_s2;
  logic              w_out_xfer;
  logic [WIDTH-1:0]  w_a_rec;
  logic [NARROW-1:0] w_b_rec;
  logic              w_mismatch;

  // A stage can take new data when empty or when its contents leave this cycle.
  assign w_s2_ready = !r_s2_valid || bus.out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign w_in_xfer  = bus.in_valid && w_s1_ready;
  assign w_s1_to_s2 = r_s1_valid && w_s2_ready;
  assign w_out_xfer = r_s2_valid && bus.out_ready;

  // Subtraction wraps naturally: 0 recovers to all-ones.
  assign w_a_rec    = r_s1_a - WIDTH'(1);
  assign w_b_rec    = r_s1_b - NARROW'(1);
  assign w_mismatch = (w_a_rec[NARROW-1:0] != w_b_rec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else begin
      // When S1 is ready its contents have either moved on or it was empty.
      if (w_s1_ready) begin
        r_s1_valid <= bus.in_valid;
      end
      if (w_in_xfer) begin
        r_s1_a <= bus.result_a;
        r_s1_b <= bus.result_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid    <= 1'b0;
      r_s2_a        <= '0;
      r_s2_mismatch <= 1'b0;
    end else begin
      if (w_s2_ready) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s1_to_s2) begin
        r_s2_a        <= w_a_rec;
        r_s2_mismatch <= w_mismatch;
      end
    end
  end

  // clr takes priority over a counting transfer in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else if (bus.clr) begin
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else if (w_out_xfer && r_s2_mismatch) begin
      r_err_sticky <= 1'b1;
      if (!(&r_err_cnt)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready   = w_s1_ready;
  assign bus.out_valid  = r_s2_valid;
  assign bus.a_rec      = r_s2_a;
  assign bus.mismatch   = r_s2_mismatch;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.err_sticky = r_err_sticky;

endmodule

// File: tb/tb_operand_recover.sv
module tb_operand_recover;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned NARROW = 7;
  localparam int unsigned CNT_W  = 8;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic             m;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  operand_recover_if #(.WIDTH(WIDTH), .NARROW(NARROW), .CNT_W(CNT_W)) bus ();

  operand_recover #(.WIDTH(WIDTH), .NARROW(NARROW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t             q[$];
  int               n_chk    = 0;
  int               n_fail   = 0;
  int               n_popped = 0;
  logic [CNT_W-1:0] m_cnt    = '0;
  logic             m_sticky = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of the recover stage, independent of the RTL structure.
  function automatic exp_t model(input logic [WIDTH-1:0] ra, input logic [NARROW-1:0] rb);
    exp_t e;
    logic [NARROW-1:0] b;
    e.a = ra - 8'd1;
    b   = rb - 7'd1;
    e.m = (e.a[NARROW-1:0] != b);
    return e;
  endfunction

  // One clock: sample handshakes before the edge, update the model, check status after.
  task automatic step(output logic accepted);
    exp_t e;
    #1;
    accepted = bus.in_valid && bus.in_ready;
    if (accepted) q.push_back(model(bus.result_a, bus.result_b));
    if (bus.out_valid && bus.out_ready) begin
      check("beat_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        n_popped++;
        check("a_rec", 32'(bus.a_rec), 32'(e.a));
        check("mismatch", 32'(bus.mismatch), 32'(e.m));
        if (e.m) begin
          m_sticky = 1'b1;
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
      end
    end
    if (bus.clr) begin
      m_cnt    = '0;
      m_sticky = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("err_cnt", 32'(bus.err_cnt), 32'(m_cnt));
    check("err_sticky", 32'(bus.err_sticky), 32'(m_sticky));
  endtask

  task automatic send(input logic [WIDTH-1:0] ra, input logic [NARROW-1:0] rb);
    logic acc;
    int   n;
    bus.in_valid = 1'b1;
    bus.result_a = ra;
    bus.result_b = rb;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      step(acc);
      n++;
    end
    check("send_accepted", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    int   n;
    bus.out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 20) begin
      step(acc);
      n++;
    end
    check("drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic acc;
    int   k;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.result_a  = '0;
    bus.result_b  = '0;
    bus.out_ready = 1'b0;
    bus.clr       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_a_rec", 32'(bus.a_rec), 32'd0);
    check("rst_mismatch", 32'(bus.mismatch), 32'd0);
    check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    check("rst_err_sticky", 32'(bus.err_sticky), 32'd0);
    rst_n = 1'b1;

    // Single beat and latency: out_valid appears after the second edge.
    bus.out_ready = 1'b1;
    send(8'h2A, 7'h2A);
    check("lat_not_yet", 32'(bus.out_valid), 32'd0);
    step(acc);
    check("lat_out_valid", 32'(bus.out_valid), 32'd1);
    check("lat_a_rec", 32'(bus.a_rec), 32'h29);
    drain();

    // Wrap-around on both paths.
    send(8'h00, 7'h00);
    send(8'h80, 7'h00);
    drain();

    // Mismatch, sticky, then clr.
    send(8'h10, 7'h05);
    drain();
    check("mm_cnt", 32'(bus.err_cnt), 32'd1);
    check("mm_sticky", 32'(bus.err_sticky), 32'd1);
    bus.clr = 1'b1;
    step(acc);
    bus.clr = 1'b0;
    check("clr_cnt", 32'(bus.err_cnt), 32'd0);
    check("clr_sticky", 32'(bus.err_sticky), 32'd0);
    // clr coinciding with a mismatching output transfer: beat not counted.
    send(8'h10, 7'h05);
    step(acc);
    check("clr_xfer_valid", 32'(bus.out_valid), 32'd1);
    bus.clr = 1'b1;
    step(acc);
    bus.clr = 1'b0;
    check("clr_xfer_cnt", 32'(bus.err_cnt), 32'd0);
    drain();

    // Backpressure: 4 stalled cycles, 2-beat capacity, then release.
    bus.out_ready = 1'b0;
    n_popped      = 0;
    k             = 1;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.result_a = 8'(k);
      bus.result_b = 7'(k);
      if (k > 2) begin
        #1;
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_hold_a_rec", 32'(bus.a_rec), 32'h00);
      end
      step(acc);
      if (acc) k++;
    end
    check("bp_accepted_two", 32'(k), 32'd3);
    bus.out_ready = 1'b1;
    while (k <= 5) begin
      bus.result_a = 8'(k);
      bus.result_b = 7'(k);
      step(acc);
      if (acc) k++;
    end
    bus.in_valid = 1'b0;
    drain();
    check("bp_count", 32'(n_popped), 32'd5);

    // Saturation with 260 back-to-back mismatching beats.
    bus.in_valid = 1'b1;
    bus.result_a = 8'h10;
    bus.result_b = 7'h05;
    for (int i = 0; i < 260; i++) step(acc);
    bus.in_valid = 1'b0;
    drain();
    check("sat_cnt", 32'(bus.err_cnt), 32'hFF);
    check("sat_sticky", 32'(bus.err_sticky), 32'd1);

    // Asynchronous reset with two beats in flight.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.result_a  = 8'h33;
    bus.result_b  = 7'h33;
    step(acc);
    step(acc);
    bus.in_valid = 1'b0;
    check("mid_out_valid_before", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_err_cnt", 32'(bus.err_cnt), 32'd0);
    check("mid_err_sticky", 32'(bus.err_sticky), 32'd0);
    check("mid_in_ready", 32'(bus.in_ready), 32'd1);
    q.delete();
    m_cnt    = '0;
    m_sticky = 1'b0;
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(acc);
      check("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_recover.md
# operand_recover

Registered inverse of the width-scoped incrementer pair: accepts the 8-bit `result_a` and 7-bit `result_b` produced by the `a + 1` sub-modules and recovers the original operand as `result - 1`. It cross-checks the low bits of both recovered values and counts disagreements. It sits downstream of the incrementer top as a self-check stage, with valid/ready handshakes on both sides and a 2-stage pipeline.

## Interface
Parameters:
- WIDTH, 8, width of the wide result path and of the recovered operand
- NARROW, 7, width of the narrow result path; must satisfy 1 ≤ NARROW ≤ WIDTH
- CNT_W, 8, width of the mismatch counter

Ports:
- clk  in  1  single clock; all state is on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept the input beat
- result_a  in  WIDTH  wide incremented value
- result_b  in  NARROW  narrow incremented value
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts the output beat
- a_rec  out  WIDTH  recovered operand, equal to result_a − 1 mod 2^WIDTH
- mismatch  out  1  a_rec[NARROW-1:0] differs from the recovered narrow value; qualified by out_valid
- err_cnt  out  CNT_W  saturating count of mismatching beats delivered
- err_sticky  out  1  set by the first delivered mismatch, held until clr
- clr  in  1  synchronous clear of err_cnt and err_sticky

## Operation
- Stage 1 (S1) registers result_a and result_b on an input transfer (`in_valid & in_ready`).
- Stage 2 (S2) registers:
  - a_rec = result_a − 1, truncated to WIDTH
  - b_rec = result_b − 1, truncated to NARROW
  - mismatch = (a_rec[NARROW-1:0] != b_rec)
- Each stage has a valid bit. A stage loads when it is empty or when its contents move on in the same cycle.
- Ready chain:
  - s2_ready = !s2_valid | out_ready
  - s1_ready = !s1_valid | s2_ready
  - in_ready = s1_ready, combinational from out_ready
- Output handshake:
  - out_valid = s2_valid.
  - a_rec and mismatch are driven from S2 registers and held stable while out_valid & !out_ready.
- Wrap-around: result_a = 0 → a_rec = 2^WIDTH−1; result_b = 0 → b_rec = 2^NARROW−1. Both cases are legal and compared normally.
- Error accounting happens on an output transfer (`out_valid & out_ready & mismatch`):
  - err_cnt increments by 1 and saturates at 2^CNT_W−1 (no wrap).
  - err_sticky is set.
- clr:
  - Sets err_cnt to 0 and clears err_sticky next edge.
  - clr in the same cycle as a counting transfer: clear wins, and that beat is not counted.
  - clr does not affect the pipeline contents.
- Simultaneous load and unload of the same stage: the new data replaces the old, and valid stays 1.
- Reset mid-operation: in-flight beats are dropped with no replay, and counters are cleared.

## Timing
- Reset values: in_ready = 1 (after reset, since the pipe is empty), out_valid = 0, a_rec = 0, mismatch = 0, err_cnt = 0, err_sticky = 0. S1 and S2 data registers are also 0.
- Latency: an input accepted at edge N is presented with out_valid = 1 after edge N+1. Consecutive beats appear on consecutive cycles.
- Throughput: 1 beat/cycle while out_ready = 1.
- Capacity: up to 2 beats buffered when out_ready = 0. in_ready drops only when both stages are full and out_ready = 0.
- err_cnt and err_sticky update at the edge that completes the output transfer.
- No combinational path from in_valid to out_valid. The only combinational path is out_ready → in_ready.

## Test plan
- Reset then single beat: result_a=0x2A, result_b=0x2A, out_ready=1 → out_valid after 2 edges, a_rec=0x29, mismatch=0, err_cnt=0.
- Wrap-around: result_a=0x00, result_b=0x00 → a_rec=0xFF, b_rec=0x7F, mismatch=0. Also result_a=0x80, result_b=0x00 → a_rec=0x7F, mismatch=0.
- Mismatch and sticky: result_a=0x10, result_b=0x05 → mismatch=1; after transfer err_cnt=1, err_sticky=1. Then clr pulse → both 0, with clr + mismatch transfer in the same cycle leaving err_cnt=0.
- Backpressure: stream 5 beats (0x01..0x05) with out_ready=0 for 4 cycles:
  - in_ready falls after 2 beats accepted.
  - a_rec holds 0x00 stable.
  - On release, the outputs arrive in order 0x00..0x04 with none lost or duplicated.
- Saturation: 260 mismatching beats → err_cnt stops at 0xFF, err_sticky=1.
- Reset mid-stream: assert rst_n=0 asynchronously with 2 beats in flight → out_valid=0 immediately, no stale beat appears after release, err_cnt=0.
